// File: rtl/shift_reg_frame_if.sv
// shift_reg_frame_if
// Bundles the control, data and status signals of shift_reg_frame.
// The master side (the datapath or a testbench) drives the controls and the
// serial/parallel inputs. The slave side (the shifter) returns the live chain,
// the serial output, the snapshotted frame and the status flags.
//   clr        : synchronous clear of chain, counter and flags
//   shift_en   : one shift step this cycle
//   din        : LANES serial input bits, bit 0 earliest
//   load       : parallel load of load_data
//   load_data  : NDATA-bit parallel load value
//   dout       : live chain contents
//   sout       : LANES serial output bits
//   frame_q    : last completed frame
//   frame_valid: one-cycle pulse after frame_q updates
//   step_cnt   : shift steps completed in the current frame
//   overrun    : sticky frame-loss flag
interface shift_reg_frame_if #(
    parameter int NDATA = 128,
    parameter int LANES = 1
);
    localparam int NSTEP = NDATA / LANES;
    localparam int NCNT  = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    logic             clr;
    logic             shift_en;
    logic [LANES-1:0] din;
    logic             load;
    logic [NDATA-1:0] load_data;
    logic [NDATA-1:0] dout;
    logic [LANES-1:0] sout;
    logic [NDATA-1:0] frame_q;
    logic             frame_valid;
    logic [NCNT-1:0]  step_cnt;
    logic             overrun;

    modport master (
        output clr, shift_en, din, load, load_data,
        input  dout, sout, frame_q, frame_valid, step_cnt, overrun
    );

    modport slave (
        input  clr, shift_en, din, load, load_data,
        output dout, sout, frame_q, frame_valid, step_cnt, overrun
    );
endinterface

// File: rtl/shift_reg_frame.sv
// shift_reg_frame
// Multi-lane SIPO/PISO shift register with frame counting. Every NDATA/LANES
// shift steps the completed word is copied into frame_q and frame_valid
// pulses for one cycle, so the chain keeps shifting without losing a frame.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous, active-low reset
//   bus : shift_reg_frame_if.slave (controls, serial/parallel data, status)
module shift_reg_frame #(
    parameter int NDATA     = 128,
    parameter int LANES     = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic               clk,
    input  logic               rst,
    shift_reg_frame_if.slave   bus
);
    localparam int NSTEP = NDATA / LANES;
    localparam int NCNT  = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam logic [NCNT-1:0] LAST_STEP = NCNT'(NSTEP - 1);

    logic [NDATA-1:0] chain;
    logic [NDATA-1:0] shifted;
    logic [NDATA-1:0] frame_reg;
    logic [NCNT-1:0]  cnt;
    logic             fv;
    logic             ovr;

    // Next chain value for a shift step; the new lanes enter at the end
    // opposite to the serial output.
    generate
        if (NDATA == LANES) begin : g_whole
            assign shifted = bus.din;
            assign bus.sout = chain;
        end else if (MSB_FIRST != 0) begin : g_msb
            assign shifted  = {chain[NDATA-LANES-1:0], bus.din};
            assign bus.sout = chain[NDATA-1 -: LANES];
        end else begin : g_lsb
            assign shifted  = {bus.din, chain[NDATA-1:LANES]};
            assign bus.sout = chain[LANES-1:0];
        end
    endgenerate

    // clr > load > shift_en > hold. frame_valid is a pulse, so it drops on
    // every cycle that does not complete a frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chain     <= '0;
            frame_reg <= '0;
            cnt       <= '0;
            fv        <= 1'b0;
            ovr       <= 1'b0;
        end else if (bus.clr) begin
            chain <= '0;
            cnt   <= '0;
            fv    <= 1'b0;
            ovr   <= 1'b0;
        end else if (bus.load) begin
            chain <= bus.load_data;
            cnt   <= '0;
            fv    <= 1'b0;
            // a partially shifted frame is being thrown away
            if (cnt != '0) begin
                ovr <= 1'b1;
            end
        end else if (bus.shift_en) begin
            chain <= shifted;
            if (cnt == LAST_STEP) begin
                cnt       <= '0;
                frame_reg <= shifted;
                fv        <= 1'b1;
                // previous frame still being presented: only possible when
                // every shift is a whole frame
                if (fv) begin
                    ovr <= 1'b1;
                end
            end else begin
                cnt <= cnt + NCNT'(1);
                fv  <= 1'b0;
            end
        end else begin
            fv <= 1'b0;
        end
    end

    assign bus.dout        = chain;
    assign bus.frame_q     = frame_reg;
    assign bus.frame_valid = fv;
    assign bus.step_cnt    = cnt;
    assign bus.overrun     = ovr;
endmodule

// File: tb/tb_shift_reg_frame.sv
// tb_shift_reg_frame
// Drives two shift_reg_frame instances (8-bit/1-lane/MSB-first and
// 8-bit/2-lane/LSB-first) with directed and random stimulus and compares
// every output against a word-level arithmetic model of the frame shifter.
module tb_shift_reg_frame;
    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] dout;
        logic [7:0] fq;
        int         cnt;
        bit         fv;
        bit         ovr;
    } model_t;

    localparam model_t MODEL_ZERO = '{dout: 8'h00, fq: 8'h00, cnt: 0, fv: 1'b0, ovr: 1'b0};

    model_t ma;
    model_t mb;

    shift_reg_frame_if #(.NDATA(8), .LANES(1)) ifa ();
    shift_reg_frame_if #(.NDATA(8), .LANES(2)) ifb ();

    shift_reg_frame #(.NDATA(8), .LANES(1), .MSB_FIRST(1)) duta (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    shift_reg_frame #(.NDATA(8), .LANES(2), .MSB_FIRST(0)) dutb (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock of a frame shifter seen as a word: the chain is multiplied or
    // divided by 2**lanes with the new bits filling the vacated end, and a
    // frame is complete after 8/lanes shifts.
    function automatic model_t modelNext(model_t m, int lanes, bit msb, bit c, bit l,
                                         logic [7:0] ld, bit s, logic [7:0] din_raw);
        model_t     n;
        int         nstep;
        logic [7:0] mask;
        logic [7:0] din;
        nstep = 8 / lanes;
        mask  = 8'((1 << lanes) - 1);
        din   = din_raw & mask;
        n     = m;
        n.fv  = 1'b0;
        if (c) begin
            n.dout = 8'h00;
            n.cnt  = 0;
            n.ovr  = 1'b0;
        end else if (l) begin
            if (m.cnt != 0) n.ovr = 1'b1;
            n.dout = ld;
            n.cnt  = 0;
        end else if (s) begin
            if (msb) n.dout = 8'(m.dout * (1 << lanes)) | din;
            else     n.dout = 8'(m.dout / (1 << lanes)) | 8'(din * (1 << (8 - lanes)));
            n.cnt = (m.cnt + 1) % nstep;
            if (n.cnt == 0) begin
                n.fq = n.dout;
                n.fv = 1'b1;
                if (m.fv) n.ovr = 1'b1;
            end
        end
        return n;
    endfunction

    function automatic logic [7:0] modelSout(model_t m, int lanes, bit msb);
        logic [7:0] mask;
        mask = 8'((1 << lanes) - 1);
        if (msb) return 8'(m.dout / (1 << (8 - lanes)));
        return m.dout & mask;
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, " A.dout"},   ifa.dout,             ma.dout);
        checkOutput({tag, " A.sout"},   8'(ifa.sout),         modelSout(ma, 1, 1'b1));
        checkOutput({tag, " A.frameq"}, ifa.frame_q,          ma.fq);
        checkOutput({tag, " A.fvalid"}, 8'(ifa.frame_valid),  8'(ma.fv));
        checkOutput({tag, " A.cnt"},    8'(ifa.step_cnt),     8'(ma.cnt));
        checkOutput({tag, " A.ovr"},    8'(ifa.overrun),      8'(ma.ovr));
        checkOutput({tag, " B.dout"},   ifb.dout,             mb.dout);
        checkOutput({tag, " B.sout"},   8'(ifb.sout),         modelSout(mb, 2, 1'b0));
        checkOutput({tag, " B.frameq"}, ifb.frame_q,          mb.fq);
        checkOutput({tag, " B.fvalid"}, 8'(ifb.frame_valid),  8'(mb.fv));
        checkOutput({tag, " B.cnt"},    8'(ifb.step_cnt),     8'(mb.cnt));
        checkOutput({tag, " B.ovr"},    8'(ifb.overrun),      8'(mb.ovr));
    endtask

    task automatic driveA(input bit c, input bit l, input logic [7:0] ld, input bit s, input logic d);
        ifa.clr = c; ifa.load = l; ifa.load_data = ld; ifa.shift_en = s; ifa.din = d;
    endtask

    task automatic driveB(input bit c, input bit l, input logic [7:0] ld, input bit s, input logic [1:0] d);
        ifb.clr = c; ifb.load = l; ifb.load_data = ld; ifb.shift_en = s; ifb.din = d;
    endtask

    // Advance both models from the inputs currently driven, then let the
    // DUTs take the same edge and sample 1 time unit later.
    task automatic applyStimulus();
        if (!rst) begin
            ma = MODEL_ZERO;
            mb = MODEL_ZERO;
        end else begin
            ma = modelNext(ma, 1, 1'b1, ifa.clr, ifa.load, ifa.load_data, ifa.shift_en, 8'(ifa.din));
            mb = modelNext(mb, 2, 1'b0, ifb.clr, ifb.load, ifb.load_data, ifb.shift_en, 8'(ifb.din));
        end
        @(posedge clk);
        #1;
    endtask

    logic sipo_bits [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic piso_bits [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [1:0] lane_vals [4] = '{2'b01, 2'b10, 2'b11, 2'b00};

    initial begin
        int pulses[$];
        int ra;
        int rb;

        // reset state
        rst = 1'b0;
        ma  = MODEL_ZERO;
        mb  = MODEL_ZERO;
        driveA(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        driveB(1'b0, 1'b0, 8'h00, 1'b0, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        checkAll("reset");
        rst = 1'b1;

        // SIPO on A: 1,0,1,1,0,0,1,0 -> B2
        for (int i = 0; i < 8; i++) begin
            driveA(1'b0, 1'b0, 8'h00, 1'b1, sipo_bits[i]);
            applyStimulus();
            checkAll($sformatf("sipo%0d", i));
        end
        checkOutput("sipo frame_q", ifa.frame_q, 8'hB2);
        checkOutput("sipo frame_valid", 8'(ifa.frame_valid), 8'h01);
        checkOutput("sipo step_cnt", 8'(ifa.step_cnt), 8'h00);
        driveA(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus();
        checkOutput("sipo pulse end", 8'(ifa.frame_valid), 8'h00);
        checkAll("sipo idle");

        // two lanes, LSB-first on B
        for (int i = 0; i < 4; i++) begin
            driveB(1'b0, 1'b0, 8'h00, 1'b1, lane_vals[i]);
            applyStimulus();
            checkAll($sformatf("lanes%0d", i));
        end
        checkOutput("lanes frame_q", ifb.frame_q, 8'h39);
        driveB(1'b0, 1'b0, 8'h00, 1'b1, 2'b11);
        applyStimulus();
        checkOutput("lanes dout5", ifb.dout, 8'hCE);
        checkOutput("lanes cnt5", 8'(ifb.step_cnt), 8'h01);
        driveB(1'b0, 1'b0, 8'h00, 1'b0, 2'b00);

        // load beats shift; load after a partial frame sets overrun; clr
        // clears it but keeps frame_q
        driveA(1'b0, 1'b1, 8'h3C, 1'b1, 1'b1);
        applyStimulus();
        checkOutput("prio dout", ifa.dout, 8'h3C);
        checkOutput("prio cnt", 8'(ifa.step_cnt), 8'h00);
        checkOutput("prio ovr0", 8'(ifa.overrun), 8'h00);
        for (int i = 0; i < 3; i++) begin
            driveA(1'b0, 1'b0, 8'h00, 1'b1, 1'($urandom_range(0, 1)));
            applyStimulus();
            checkAll($sformatf("prio shift%0d", i));
        end
        driveA(1'b0, 1'b1, 8'h3C, 1'b1, 1'b0);
        applyStimulus();
        checkOutput("prio ovr1", 8'(ifa.overrun), 8'h01);
        checkOutput("prio dout2", ifa.dout, 8'h3C);
        driveA(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        applyStimulus();
        checkOutput("clr ovr", 8'(ifa.overrun), 8'h00);
        checkOutput("clr frame_q", ifa.frame_q, 8'hB2);
        checkOutput("clr dout", ifa.dout, 8'h00);
        checkAll("clr");

        // PISO on A: A5 shifted out MSB first
        driveA(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
        applyStimulus();
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("piso sout%0d", i), 8'(ifa.sout), 8'(piso_bits[i]));
            driveA(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            applyStimulus();
            checkAll($sformatf("piso%0d", i));
        end
        checkOutput("piso dout", ifa.dout, 8'h00);

        // continuous stream: 24 shifts -> 3 pulses at 8, 16, 24
        driveA(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus();
        for (int i = 1; i <= 24; i++) begin
            driveA(1'b0, 1'b0, 8'h00, 1'b1, 1'($urandom_range(0, 1)));
            applyStimulus();
            checkAll($sformatf("stream%0d", i));
            if (ifa.frame_valid) pulses.push_back(i);
        end
        checkOutput("stream pulses", 8'(pulses.size()), 8'd3);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("stream pos%0d", k),
                        8'((k < pulses.size()) ? pulses[k] : 255), 8'(8 * (k + 1)));
        end

        // asynchronous reset mid-frame
        for (int i = 0; i < 3; i++) begin
            driveA(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
            driveB(1'b0, 1'b0, 8'h00, 1'b1, 2'b10);
            applyStimulus();
        end
        checkAll("pre-reset");
        rst = 1'b0;
        ma  = MODEL_ZERO;
        mb  = MODEL_ZERO;
        #2;
        checkOutput("async A.dout", ifa.dout, 8'h00);
        checkOutput("async A.frameq", ifa.frame_q, 8'h00);
        checkAll("async reset");
        applyStimulus();
        applyStimulus();
        checkAll("reset held");
        rst = 1'b1;
        applyStimulus();
        checkAll("after release");

        // random traffic on both instances
        for (int i = 0; i < 400; i++) begin
            ra = int'($urandom_range(0, 99));
            rb = int'($urandom_range(0, 99));
            driveA(ra < 3, ra >= 3 && ra < 9, 8'($urandom), $urandom_range(0, 3) != 0,
                   1'($urandom_range(0, 1)));
            driveB(rb < 3, rb >= 3 && rb < 9, 8'($urandom), $urandom_range(0, 3) != 0,
                   2'($urandom_range(0, 3)));
            applyStimulus();
            checkAll($sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
